// File: rtl/vga_pkg.sv
// Shared codes for the reaction-time game: the image-select values understood by
// the VGA image mux, the controller state encoding and the LFSR seed.
package vga_pkg;

    // Image-select codes; the VGA image mux decodes these same values
    localparam logic [2:0] SCR_MENU   = 3'd0;
    localparam logic [2:0] SCR_RED    = 3'd1;
    localparam logic [2:0] SCR_GREEN  = 3'd2;
    localparam logic [2:0] SCR_RESULT = 3'd3;
    localparam logic [2:0] SCR_EARLY  = 3'd4;

    // Controller states; GO_PEND and GO both show the green image
    typedef logic [2:0] ctrlState_t;
    localparam ctrlState_t ST_MENU    = 3'd0;
    localparam ctrlState_t ST_DELAY   = 3'd1;
    localparam ctrlState_t ST_GO_PEND = 3'd2;
    localparam ctrlState_t ST_GO      = 3'd3;
    localparam ctrlState_t ST_RESULT  = 3'd4;
    localparam ctrlState_t ST_EARLY   = 3'd5;

    // Non-zero seed so the LFSR never locks up in the all-zero state
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Image shown while the controller sits in a given state
    function automatic logic [2:0] screenOf(input ctrlState_t st);
        logic [2:0] scr;
        scr = SCR_MENU;
        case (st)
            ST_MENU:    scr = SCR_MENU;
            ST_DELAY:   scr = SCR_RED;
            ST_GO_PEND: scr = SCR_GREEN;
            ST_GO:      scr = SCR_GREEN;
            ST_RESULT:  scr = SCR_RESULT;
            ST_EARLY:   scr = SCR_EARLY;
            default:    scr = SCR_MENU;
        endcase
        return scr;
    endfunction

    // One step of the 16-bit Fibonacci LFSR with taps 16,14,13,11
    function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
        logic feedback;
        feedback = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], feedback};
    endfunction

endpackage

// File: rtl/reaction_test_ctrl_ms_timer.sv
// Millisecond time base: a cycle prescaler feeding a saturating millisecond counter.
// Both restart from zero whenever clear is asserted.
module ms_timer #(
    parameter int CYCLES_PER_MS = 50000,
    parameter int WIDTH         = 14,
    parameter int MAX_COUNT     = 9999
) (
    input  logic             clk,
    input  logic             iResetn,
    input  logic             clear,
    output logic             tick,
    output logic [WIDTH-1:0] count
);

    localparam int PRE_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;

    logic [PRE_W-1:0] prescaler;

    assign tick = (prescaler == PRE_W'(CYCLES_PER_MS - 1));

    // Prescaler wraps every millisecond; the count saturates so it never passes MAX_COUNT
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            prescaler <= '0;
            count     <= '0;
        end else if (clear) begin
            prescaler <= '0;
            count     <= '0;
        end else if (tick) begin
            prescaler <= '0;
            if (count != WIDTH'(MAX_COUNT)) begin
                count <= count + WIDTH'(1);
            end
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

endmodule

// File: rtl/reaction_test_ctrl.sv
// Game-flow sequencer for the reaction-time benchmark: chooses the image to draw,
// waits a pseudo-random red period, then times the player from the first fully
// drawn green frame until the key press (or a timeout).
module reaction_test_ctrl
    import vga_pkg::*;
#(
    parameter int CYCLES_PER_MS = 50000,
    parameter int MIN_DELAY_MS  = 1000,
    parameter int RAND_BITS     = 11,
    parameter int MAX_MS        = 9999
) (
    input  logic        clk,
    input  logic        iResetn,
    input  logic        iKeyPress,
    input  logic        iFrameDone,
    output logic [2:0]  oScreenSel,
    output logic        oScreenChg,
    output logic [13:0] oReactionMs,
    output logic        oResultValid,
    output logic        oTimeout
);

    // The red delay must fit the 14-bit target register
    generate
        if ((RAND_BITS < 1) || (RAND_BITS > 16) ||
            (MIN_DELAY_MS + (1 << RAND_BITS) - 1 >= (1 << 14))) begin : gBadDelayRange
            $error("reaction_test_ctrl: MIN_DELAY_MS + 2**RAND_BITS - 1 must be below 2**14");
        end
    endgenerate

    ctrlState_t  state;
    ctrlState_t  nextState;
    logic        keyPrev;
    logic        press;
    logic [15:0] lfsr;
    logic [13:0] target;
    logic [13:0] msCount;
    logic        tick;
    logic        timerClear;
    logic        enterDelay;
    logic        resultPress;
    logic        resultTimeout;

    assign press = iKeyPress & ~keyPrev;

    ms_timer #(
        .CYCLES_PER_MS (CYCLES_PER_MS),
        .WIDTH         (14),
        .MAX_COUNT     (MAX_MS)
    ) uTimer (
        .clk     (clk),
        .iResetn (iResetn),
        .clear   (timerClear),
        .tick    (tick),
        .count   (msCount)
    );

    // Next-state decision; a press always beats a tick or frame-done in the same cycle
    always_comb begin
        nextState     = state;
        resultPress   = 1'b0;
        resultTimeout = 1'b0;
        case (state)
            ST_MENU: begin
                if (press) nextState = ST_DELAY;
            end
            ST_DELAY: begin
                if (press) begin
                    nextState = ST_EARLY;
                end else if (tick && (msCount + 14'd1 == target)) begin
                    nextState = ST_GO_PEND;
                end
            end
            ST_GO_PEND: begin
                if (press) begin
                    nextState = ST_EARLY;
                end else if (iFrameDone) begin
                    nextState = ST_GO;
                end
            end
            ST_GO: begin
                if (press) begin
                    nextState   = ST_RESULT;
                    resultPress = 1'b1;
                end else if (tick && (msCount + 14'd1 == 14'(MAX_MS))) begin
                    nextState     = ST_RESULT;
                    resultTimeout = 1'b1;
                end
            end
            ST_RESULT: begin
                if (press) nextState = ST_MENU;
            end
            ST_EARLY: begin
                if (press) nextState = ST_MENU;
            end
            default: nextState = ST_MENU;
        endcase
    end

    // Timer restarts on entry to the red wait and to the timed green phase
    always_comb begin
        enterDelay = (nextState == ST_DELAY) && (state != ST_DELAY);
        timerClear = enterDelay || ((nextState == ST_GO) && (state != ST_GO));
    end

    // State and image select move together; the change pulse flags a new image code
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state      <= ST_MENU;
            oScreenSel <= SCR_MENU;
            oScreenChg <= 1'b0;
        end else begin
            state      <= nextState;
            oScreenSel <= screenOf(nextState);
            oScreenChg <= (screenOf(nextState) != oScreenSel);
        end
    end

    // Key edge detector and free-running LFSR
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            keyPrev <= 1'b0;
            lfsr    <= LFSR_SEED;
        end else begin
            keyPrev <= iKeyPress;
            lfsr    <= lfsrNext(lfsr);
        end
    end

    // Red-screen length is sampled from the LFSR at the moment the red wait starts
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            target <= '0;
        end else if (enterDelay) begin
            target <= 14'(MIN_DELAY_MS) + 14'(lfsr[RAND_BITS-1:0]);
        end
    end

    // Result register, one-cycle valid pulse and sticky timeout flag
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            oReactionMs  <= '0;
            oResultValid <= 1'b0;
            oTimeout     <= 1'b0;
        end else begin
            oResultValid <= resultPress | resultTimeout;
            if (resultPress) begin
                oReactionMs <= msCount;
            end else if (resultTimeout) begin
                oReactionMs <= 14'(MAX_MS);
            end
            if (enterDelay) begin
                oTimeout <= 1'b0;
            end else if (resultTimeout) begin
                oTimeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/reaction_test_ctrl.md
Name: reaction_test_ctrl

Overview:
Game-flow sequencer for the reaction-time benchmark.
- Decides which full-screen image the VGA drawing FSM renders: menu, red wait, green go, result, too-early.
- Generates a pseudo-random red-screen delay.
- Measures reaction time in milliseconds, starting from the first completed frame of the green screen.
- Sits between the debounced key input, the VGA drawing FSM (its frame-done pulse and image select) and the score display.

Parameters:
CYCLES_PER_MS, 50000, clk cycles per millisecond tick (50 MHz clock)
MIN_DELAY_MS, 1000, minimum red-screen duration in ms
RAND_BITS, 11, number of LFSR bits added to MIN_DELAY_MS (adds 0..2^RAND_BITS-1 ms)
MAX_MS, 9999, reaction timeout in ms; also saturation value of oReactionMs

Ports:
clk  in  1  system clock
iResetn  in  1  asynchronous active-low reset
iKeyPress  in  1  debounced, clk-synchronous key level; 1 = pressed
iFrameDone  in  1  one-cycle pulse from the VGA drawing FSM when a full frame write completes
oScreenSel  out  3  image select: 0 MENU, 1 RED, 2 GREEN, 3 RESULT, 4 EARLY
oScreenChg  out  1  one-cycle pulse in the cycle oScreenSel takes a new value
oReactionMs  out  14  last measured reaction time in ms
oResultValid  out  1  one-cycle pulse when oReactionMs is updated
oTimeout  out  1  1 when the last result was a timeout; cleared at the next DELAY entry

Behaviour:
- All state is in flops on clk with async clear on iResetn low.
- Reset values:
  - state MENU
  - oScreenSel 0
  - oScreenChg 0
  - oReactionMs 0
  - oResultValid 0
  - oTimeout 0
  - key_prev 0
  - LFSR 16'hACE1
  - counters 0
- Reset asserted mid-operation: forces all of the above immediately (async); no result pulse is emitted.
- Press edge: press = iKeyPress & ~key_prev. key_prev is registered every cycle. Only press edges cause transitions; held keys do not.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle out of reset.
- Millisecond timer:
  - prescaler runs 0..CYCLES_PER_MS-1; tick when prescaler == CYCLES_PER_MS-1.
  - On a tick: prescaler wraps to 0 and ms_count increments.
  - Both are cleared on entry to DELAY and to GO.
- States (oScreenSel registered, updated together with the state):
  - MENU (0): press -> DELAY. On entry to DELAY: target = MIN_DELAY_MS + lfsr[RAND_BITS-1:0] captured, oTimeout cleared.
  - DELAY (1): press -> EARLY. Else tick with ms_count+1 == target -> GO_PEND. Press wins if both occur in the same cycle.
  - GO_PEND (2): waits for the green image to be fully drawn. press -> EARLY (press wins over iFrameDone in the same cycle). iFrameDone -> GO.
  - GO (2): timing runs.
    - press -> RESULT; oReactionMs <= ms_count (value before any same-cycle increment); oResultValid = 1 for one cycle.
    - Else tick with ms_count+1 == MAX_MS -> RESULT; oReactionMs <= MAX_MS; oTimeout <= 1; oResultValid pulse.
  - RESULT (3): press -> MENU.
  - EARLY (4): press -> MENU. oReactionMs is unchanged in this path.
- oScreenChg pulses in the same cycle oScreenSel changes. GO_PEND -> GO keeps code 2, so there is no pulse on that transition.
- Timing relation: with GO entered at cycle t0, a press sampled at t0+k reports floor(k/CYCLES_PER_MS) ms.
- Width rules:
  - ms_count is 14 bits and never exceeds MAX_MS.
  - Prescaler width is clog2(CYCLES_PER_MS).
  - target is 14 bits; MIN_DELAY_MS + 2^RAND_BITS - 1 must be < 2^14, checked by an elaboration assertion.
- iFrameDone is ignored outside GO_PEND.

Decomposition:
- Shared package (vga_pkg):
  - screen-select codes SCR_MENU/RED/GREEN/RESULT/EARLY, also used by the VGA image mux
  - controller state encoding
  - LFSR seed constant
- One sub-module, ms_timer:
  - contains the prescaler and ms_count with clear input, tick output and count output
  - parameterised by CYCLES_PER_MS and width

Test Plan (CYCLES_PER_MS=4, MIN_DELAY_MS=2, RAND_BITS=2, MAX_MS=20):
1. Release reset, no key for 100 cycles -> oScreenSel=0, oScreenChg never pulses, all outputs 0.
2. Press -> oScreenSel=1 with a 1-cycle oScreenChg; red lasts 8..20 cycles -> oScreenSel=2; pulse iFrameDone; press 10 cycles after GO entry -> oReactionMs=2, oResultValid for exactly 1 cycle, oScreenSel=3; next press -> 0.
3. Press in DELAY 3 cycles after entry -> oScreenSel=4, no oResultValid, oReactionMs unchanged; next press -> 0.
4. In GO_PEND, assert a press and iFrameDone in the same cycle -> EARLY (oScreenSel=4); held key level with no new edge -> no further transition.
5. Reach GO and no press for 80 cycles -> oReactionMs=20, oTimeout=1, oResultValid pulse, oScreenSel=3; next MENU->DELAY press clears oTimeout.
6. Drop iResetn during GO mid-count -> oScreenSel=0 and all outputs 0 asynchronously, before the next clk edge; after release, the next press starts a fresh DELAY.
